// File: rtl/matrix_row_loader.sv
// Reads one row (A) or N rows (B) of 32-bit words from data memory, assembles
// each row into an N-word vector and publishes it with a one-cycle strobe.
module matrix_row_loader #(
  parameter int N    = 16,
  parameter int REGN = 512,
  localparam int AW  = $clog2(REGN),
  localparam int CW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              LOAD_A,
  input  logic [AW-1:0]     BASE_ADDR,
  output logic              MEM_RD,
  output logic [AW-1:0]     MEM_ADDR,
  input  logic [31:0]       MEM_RDATA,
  output logic [N*32-1:0]   MAT_IN,
  output logic              MATAB_MUX,
  output logic [CW-1:0]     SEQ_B,
  output logic              DONE_DATAB,
  output logic              LOAD_DONE,
  output logic              BUSY
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, PUBLISH} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] base_reg;
  logic          mode_reg;
  logic [CW-1:0] rows_m1_reg;
  logic [CW-1:0] row_reg;
  logic [CW-1:0] col_reg;
  logic          rd_q_reg;
  logic [CW-1:0] col_q_reg;
  logic          matab_mux_reg;
  logic [CW-1:0] seq_b_reg;
  logic          done_datab_reg;
  logic          load_done_reg;
  logic [AW-1:0] addr_off;

  logic [31:0]   asm_buf   [N];
  logic [31:0]   asm_fwd   [N];
  logic [31:0]   mat_word_reg [N];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (START) state_next = READ;
      READ:    if (col_reg == CW'(N - 1)) state_next = DRAIN;
      DRAIN:   state_next = PUBLISH;
      PUBLISH: state_next = (row_reg == rows_m1_reg) ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  // Load context, read sequencing and the registered publish strobes.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      base_reg       <= '0;
      mode_reg       <= 1'b0;
      rows_m1_reg    <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      rd_q_reg       <= 1'b0;
      col_q_reg      <= '0;
      matab_mux_reg  <= 1'b0;
      seq_b_reg      <= '0;
      done_datab_reg <= 1'b0;
      load_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (START) begin
            base_reg    <= BASE_ADDR;
            mode_reg    <= LOAD_A;
            rows_m1_reg <= LOAD_A ? '0 : {CW{1'b1}};
            row_reg     <= '0;
            col_reg     <= '0;
          end
        end
        READ: col_reg <= col_reg + 1'b1;
        PUBLISH: begin
          if (row_reg != rows_m1_reg) begin
            row_reg <= row_reg + 1'b1;
            col_reg <= '0;
          end
        end
        default: ;
      endcase
      rd_q_reg       <= (state_reg == READ);
      col_q_reg      <= col_reg;
      done_datab_reg <= (state_reg == DRAIN);
      load_done_reg  <= (state_reg == DRAIN) && (row_reg == rows_m1_reg);
      if (state_reg == DRAIN) begin
        seq_b_reg     <= row_reg;
        matab_mux_reg <= mode_reg;
      end
    end
  end

  // The last word lands on the same edge that publishes, so forward it.
  for (genvar gi = 0; gi < N; gi++) begin : g_word
    assign asm_fwd[gi] = (rd_q_reg && (col_q_reg == CW'(gi))) ? MEM_RDATA : asm_buf[gi];

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        asm_buf[gi]      <= '0;
        mat_word_reg[gi] <= '0;
      end else begin
        asm_buf[gi] <= asm_fwd[gi];
        if (state_reg == DRAIN) mat_word_reg[gi] <= asm_fwd[gi];
      end
    end

    assign MAT_IN[gi*32 +: 32] = mat_word_reg[gi];
  end

  // row*N + col is a concatenation because N is a power of two.
  assign addr_off   = AW'({row_reg, col_reg});
  assign MEM_RD     = (state_reg == READ);
  assign MEM_ADDR   = (state_reg == READ) ? (base_reg + addr_off) : '0;
  assign BUSY       = (state_reg != IDLE);
  assign MATAB_MUX  = matab_mux_reg;
  assign SEQ_B      = seq_b_reg;
  assign DONE_DATAB = done_datab_reg;
  assign LOAD_DONE  = load_done_reg;

endmodule

// File: tb/tb_matrix_row_loader.sv
// Self-checking bench for matrix_row_loader: a memory model, a scoreboard of
// expected reads and published rows, and one task per scenario.
module tb_matrix_row_loader;
  localparam int N    = 16;
  localparam int REGN = 512;
  localparam int AW   = 9;
  localparam int CW   = 4;
  localparam int ROWC = N + 2;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic            START;
  logic            LOAD_A;
  logic [AW-1:0]   BASE_ADDR;
  logic            MEM_RD;
  logic [AW-1:0]   MEM_ADDR;
  logic [31:0]     MEM_RDATA;
  logic [N*32-1:0] MAT_IN;
  logic            MATAB_MUX;
  logic [CW-1:0]   SEQ_B;
  logic            DONE_DATAB;
  logic            LOAD_DONE;
  logic            BUSY;

  matrix_row_loader #(.N(N), .REGN(REGN)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .LOAD_A(LOAD_A), .BASE_ADDR(BASE_ADDR),
    .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA), .MAT_IN(MAT_IN),
    .MATAB_MUX(MATAB_MUX), .SEQ_B(SEQ_B), .DONE_DATAB(DONE_DATAB),
    .LOAD_DONE(LOAD_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory contents: address in the low bits, a marker and address byte above.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0], 15'h2A5A, a};
  endfunction

  always @(posedge CLK) MEM_RDATA <= MEM_RD ? mem_word(MEM_ADDR) : 32'hDEAD_BEEF;

  typedef struct {
    logic [N*32-1:0] mat;
    logic [CW-1:0]   seq;
    logic            mode;
    logic            last;
    int              due;
  } row_t;

  row_t          row_q[$];
  logic [AW-1:0] addr_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [N*32-1:0] last_mat  = '0;
  logic [CW-1:0]   last_seq  = '0;
  logic            last_mode = 1'b0;

  // Called at a negedge; the START sample is on the following posedge.
  task automatic drive_start(input logic [AW-1:0] base, input logic a);
    row_t          e;
    logic [AW-1:0] ad;
    int            rows;
    rows = a ? 1 : N;
    START = 1'b1; LOAD_A = a; BASE_ADDR = base;
    for (int r = 0; r < rows; r++) begin
      e.mat = '0;
      for (int c = 0; c < N; c++) begin
        ad = base + AW'(r * N + c);
        addr_q.push_back(ad);
        e.mat[c*32 +: 32] = mem_word(ad);
      end
      e.seq  = CW'(r);
      e.mode = a;
      e.last = (r == rows - 1);
      e.due  = cyc + (r + 1) * ROWC;
      row_q.push_back(e);
    end
    @(negedge CLK);
    START = 1'b0; LOAD_A = ~a; BASE_ADDR = AW'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string tag, output int t_idle);
    int k;
    k = 0;
    while ((BUSY !== 1'b0 || row_q.size() != 0) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    t_idle = cyc;
    n_vec++;
    if (k >= budget || row_q.size() != 0 || addr_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_complete: rows left %0d, reads left %0d, waited %0d of %0d cycles",
               tag, row_q.size(), addr_q.size(), k, budget);
      row_q.delete();
      addr_q.delete();
    end
  endtask

  // Scoreboard: reads and published rows are popped as the DUT produces them.
  always @(negedge CLK) begin
    row_t          er;
    logic [AW-1:0] ea;
    if (RSTN === 1'b1) begin
      if (MEM_RD === 1'b1) begin
        n_vec++;
        if (addr_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_extra: read at %h, no read expected", MEM_ADDR);
        end else begin
          ea = addr_q.pop_front();
          if (MEM_ADDR !== ea) begin
            n_err++;
            $display("FAIL rd_addr: got %h, expected %h", MEM_ADDR, ea);
          end
        end
      end
      if (DONE_DATAB === 1'b1) begin
        n_vec++;
        if (row_q.size() == 0) begin
          n_err++;
          $display("FAIL pub_extra: row published (seq %0d), none expected", SEQ_B);
        end else begin
          er = row_q.pop_front();
          if (MAT_IN !== er.mat) begin
            n_err++;
            $display("FAIL pub_mat: got %h expected %h", MAT_IN, er.mat);
          end
          n_vec++;
          if (SEQ_B !== er.seq || MATAB_MUX !== er.mode) begin
            n_err++;
            $display("FAIL pub_tag: seq/mux got %0d/%b expected %0d/%b", SEQ_B, MATAB_MUX, er.seq, er.mode);
          end
          n_vec++;
          if (LOAD_DONE !== er.last) begin
            n_err++;
            $display("FAIL pub_load_done: got %b expected %b", LOAD_DONE, er.last);
          end
          n_vec++;
          if (cyc !== er.due) begin
            n_err++;
            $display("FAIL pub_time: published at cycle %0d, expected %0d", cyc, er.due);
          end
          last_mat  = er.mat;
          last_seq  = er.seq;
          last_mode = er.mode;
          $display("row seq=%0d mode=%b last=%b cycle=%0d", er.seq, er.mode, er.last, cyc);
        end
      end else if (LOAD_DONE !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL load_done_stray: got %b without DONE_DATAB, expected 0", LOAD_DONE);
      end
    end
  end

  task automatic test_reset();
    RSTN = 1'b0; START = 1'b0; LOAD_A = 1'b0; BASE_ADDR = '0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if (MAT_IN !== '0 || SEQ_B !== '0 || MATAB_MUX !== 1'b0 || DONE_DATAB !== 1'b0 ||
        LOAD_DONE !== 1'b0 || MEM_RD !== 1'b0 || MEM_ADDR !== '0 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: mat %h seq %0d mux %b done %b ld %b rd %b addr %h busy %b, all expected 0",
               MAT_IN, SEQ_B, MATAB_MUX, DONE_DATAB, LOAD_DONE, MEM_RD, MEM_ADDR, BUSY);
    end
    RSTN = 1'b1;
    @(negedge CLK);
    $display("reset checked at cycle %0d", cyc);
  endtask

  task automatic test_load_a();
    int c, t;
    c = cyc;
    drive_start(9'h020, 1'b1);
    wait_idle(60, "load_a", t);
    n_vec++;
    if (t !== c + ROWC + 1) begin
      n_err++;
      $display("FAIL load_a_len: idle at cycle %0d, expected %0d", t, c + ROWC + 1);
    end
    $display("A load base=020 done, idle at cycle %0d", t);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      n_vec++;
      if (MAT_IN !== last_mat || SEQ_B !== last_seq || MATAB_MUX !== last_mode ||
          MEM_RD !== 1'b0 || DONE_DATAB !== 1'b0 || LOAD_DONE !== 1'b0 || BUSY !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d: seq %0d mux %b rd %b done %b ld %b busy %b mat %h, expected seq %0d mux %b idle mat %h",
                 i, SEQ_B, MATAB_MUX, MEM_RD, DONE_DATAB, LOAD_DONE, BUSY, MAT_IN,
                 last_seq, last_mode, last_mat);
      end
    end
    $display("hold of 50 idle cycles checked");
  endtask

  task automatic test_load_b();
    int c, t;
    c = cyc;
    drive_start(9'h100, 1'b0);
    repeat (16) @(negedge CLK);
    n_vec++;
    if (MATAB_MUX !== 1'b1) begin
      n_err++;
      $display("FAIL b_mux_hold: MATAB_MUX %b before first B row, expected 1", MATAB_MUX);
    end
    wait_idle(N * ROWC + 40, "load_b", t);
    n_vec++;
    if (t !== c + N * ROWC + 1) begin
      n_err++;
      $display("FAIL load_b_len: idle at cycle %0d, expected %0d", t, c + N * ROWC + 1);
    end
    $display("B load base=100 done, idle at cycle %0d", t);
  endtask

  task automatic test_wrap();
    int t;
    drive_start(9'h1F8, 1'b1);
    repeat (16) @(negedge CLK);
    n_vec++;
    if (MATAB_MUX !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_mux_hold: MATAB_MUX %b before A row, expected 0", MATAB_MUX);
    end
    wait_idle(60, "wrap", t);
    $display("wrap load base=1F8 done at cycle %0d", t);
  endtask

  task automatic test_busy_start();
    int c, t;
    c = cyc;
    drive_start(9'h040, 1'b1);
    while (cyc < c + ROWC && cyc < c + 100) begin
      START     = (cyc == c + 3) || (cyc == c + 10);
      LOAD_A    = 1'b0;
      BASE_ADDR = 9'h0AA;
      @(negedge CLK);
      n_vec++;
      if (BUSY !== 1'b1) begin
        n_err++;
        $display("FAIL busy_start_busy: BUSY %b at cycle %0d, expected 1", BUSY, cyc);
      end
    end
    // In the PUBLISH cycle of the only row: must be ignored.
    START = 1'b1; LOAD_A = 1'b0; BASE_ADDR = 9'h155;
    @(negedge CLK);
    n_vec++;
    if (BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_publish: BUSY %b after last publish, expected 0", BUSY);
    end
    drive_start(9'h155, 1'b0);
    repeat (16) @(negedge CLK);
    n_vec++;
    if (MATAB_MUX !== 1'b1) begin
      n_err++;
      $display("FAIL busy_mux_hold: MATAB_MUX %b before first B row, expected 1", MATAB_MUX);
    end
    wait_idle(N * ROWC + 40, "busy_start", t);
    $display("busy START test done at cycle %0d", t);
  endtask

  task automatic test_reset_midload();
    int c, t;
    c = cyc;
    drive_start(9'h080, 1'b0);
    while (cyc < c + 40) @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    n_vec++;
    if (MAT_IN !== '0 || SEQ_B !== '0 || MATAB_MUX !== 1'b0 || DONE_DATAB !== 1'b0 ||
        LOAD_DONE !== 1'b0 || MEM_RD !== 1'b0 || MEM_ADDR !== '0 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL midload_reset: mat %h seq %0d mux %b done %b ld %b rd %b addr %h busy %b, all expected 0",
               MAT_IN, SEQ_B, MATAB_MUX, DONE_DATAB, LOAD_DONE, MEM_RD, MEM_ADDR, BUSY);
    end
    row_q.delete();
    addr_q.delete();
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    drive_start(9'h1F0, 1'b0);
    wait_idle(N * ROWC + 40, "after_reset", t);
    $display("load after mid-load reset done at cycle %0d", t);
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_hold();
    test_load_b();
    test_wrap();
    test_busy_start();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
